// File: rtl/spi_cfg_ctrl.sv
// rtl/spi_cfg_ctrl.sv - SPI mode-0 slave writing eight 8-bit config registers.
// Optional macro SPI_CFG_READBACK_EN enables read frames returning reg[addr] on spi_miso.
module spi_cfg_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [63:0] cfg,
    output logic        wr_stb,
    output logic [2:0]  wr_addr,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic [SYNC_STAGES:0]   vld;
    logic                   cs_q, sck_q, armed;
    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_fall, cs_rise, sck_rise;
    logic [3:0]             cnt;
    logic [6:0]             sh;
    logic [7:0]             shift_byte;
    logic                   rw;
    logic [2:0]             addr;
    logic                   cnt_clr, do_shift, latch_cmd, commit, set_err;

    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    // A low cs seen right after reset is not a fresh frame start: wait until cs is
    // genuinely observed high once the synchronizer has flushed its reset values.
    assign cs_fall    = armed & cs_q & ~cs_s;
    assign cs_rise    = ~cs_q & cs_s;
    assign sck_rise   = sck_s & ~sck_q;
    assign shift_byte = {sh, mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        do_shift  = 1'b0;
        latch_cmd = 1'b0;
        commit    = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n = CMD;
                    cnt_clr = 1'b1;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else if (sck_rise) begin
                    do_shift = 1'b1;
                    if (cnt == 4'd7) begin
                        latch_cmd = 1'b1;
                        state_n   = DATA;
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else if (sck_rise) begin
                    do_shift = 1'b1;
                    if (cnt == 4'd15) begin
                        commit  = rw;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            vld       <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            armed     <= 1'b0;
            cnt       <= 4'd0;
            sh        <= 7'd0;
            rw        <= 1'b0;
            addr      <= 3'd0;
            cfg       <= 64'd0;
            wr_stb    <= 1'b0;
            wr_addr   <= 3'd0;
            frame_err <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            vld       <= {vld[SYNC_STAGES-1:0], 1'b1};
            cs_q      <= cs_s;
            sck_q     <= sck_s;
            if (vld[SYNC_STAGES] && cs_s) begin
                armed <= 1'b1;
            end
            if (cnt_clr) begin
                cnt <= 4'd0;
            end else if (do_shift) begin
                cnt <= cnt + 4'd1;
            end
            if (do_shift) begin
                sh <= shift_byte[6:0];
            end
            if (latch_cmd) begin
                rw   <= shift_byte[7];
                addr <= shift_byte[2:0];
            end
            wr_stb <= commit;
            if (commit) begin
                cfg[{addr, 3'b000} +: 8] <= shift_byte;
                wr_addr                  <= addr;
            end
            if (set_err) begin
                frame_err <= 1'b1;
            end
        end
    end

`ifdef SPI_CFG_READBACK_EN
    logic [7:0] tx;
    logic       sck_fall;

    assign sck_fall = sck_q & ~sck_s;
    assign spi_miso = (state == DATA) & tx[7];

    // The fall right after the 8th rise must not shift: bit 7 has to be on the
    // line for the 9th rise, so shifting starts once a data bit has been clocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx <= 8'd0;
        end else if (latch_cmd) begin
            tx <= shift_byte[7] ? 8'd0 : cfg[{shift_byte[2:0], 3'b000} +: 8];
        end else if (state == DATA && sck_fall && cnt > 4'd8) begin
            tx <= {tx[6:0], 1'b0};
        end
    end
`else
    assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// tb/tb_spi_cfg_ctrl.sv - directed self-checking bench for spi_cfg_ctrl.
module tb_spi_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [63:0] cfg;
    logic        wr_stb;
    logic [2:0]  wr_addr;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stb_cnt = 0;
    int stb_cyc = 0;
    int rise_cyc = 0;
    int miso_hi = 0;

    spi_cfg_ctrl #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .cfg      (cfg),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cnt <= stb_cnt + 1;
            stb_cyc <= cyc;
        end
        if (spi_miso) miso_hi <= miso_hi + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        clks(4);
        rst = 1'b0;
        clks(4);
    endtask

    // Shift bits first..last of w; miso is sampled just before each rise 9..16.
    task automatic send_bits(input logic [15:0] w, input int first, input int last,
                             output logic [7:0] rb);
        rb = 8'd0;
        for (int i = first; i <= last; i++) begin
            spi_mosi = w[15-i];
            clks(4);
            if (i >= 8) rb[15-i] = spi_miso;
            spi_sck = 1'b1;
            if (i == 15) rise_cyc = cyc;
            clks(8);
            spi_sck = 1'b0;
            clks(4);
        end
    endtask

    task automatic frame(input logic [15:0] w, input int gap, output logic [7:0] rb);
        spi_cs_n = 1'b0;
        clks(8);
        send_bits(w, 0, 15, rb);
        clks(4);
        spi_cs_n = 1'b1;
        clks(gap);
    endtask

    logic [7:0] rb;
    int         base;

    initial begin
        do_reset();
        chk("rst_cfg", cfg, 64'd0);
        chk("rst_stb", wr_stb, 1'b0);
        chk("rst_addr", wr_addr, 3'd0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_miso", spi_miso, 1'b0);

        // single write to reg 2
        base = stb_cnt;
        frame(16'h82A5, 10, rb);
        chk("w1_cfg", cfg, 64'h0000_0000_00A5_0000);
        chk("w1_stb", stb_cnt - base, 1);
        chk("w1_addr", wr_addr, 3'd2);
        chk("w1_err", frame_err, 1'b0);
        chk("w1_lat", (stb_cyc - rise_cyc) <= 4, 1'b1);

        // back-to-back writes with a 6-clk cs gap
        do_reset();
        base = stb_cnt;
        frame(16'h8711, 6, rb);
        frame(16'h8022, 10, rb);
        chk("b2b_cfg", cfg, 64'h1100_0000_0000_0022);
        chk("b2b_stb", stb_cnt - base, 2);
        chk("b2b_addr", wr_addr, 3'd0);

        // abort after 11 bits
        do_reset();
        base = stb_cnt;
        spi_cs_n = 1'b0;
        clks(8);
        send_bits(16'h8355, 0, 10, rb);
        spi_cs_n = 1'b1;
        clks(10);
        chk("abt_cfg", cfg, 64'd0);
        chk("abt_stb", stb_cnt - base, 0);
        chk("abt_err", frame_err, 1'b1);
        frame(16'h8166, 10, rb);
        chk("abt_sticky", frame_err, 1'b1);
        chk("abt_next", cfg, 64'h0000_0000_0000_6600);
        do_reset();
        chk("abt_clr", frame_err, 1'b0);

        // extra sck pulses in HOLD are ignored
        base = stb_cnt;
        spi_cs_n = 1'b0;
        clks(8);
        send_bits(16'h8499, 0, 15, rb);
        send_bits(16'hFFFF, 0, 4, rb);
        clks(4);
        spi_cs_n = 1'b1;
        clks(10);
        chk("hold_cfg", cfg, 64'h0000_0099_0000_0000);
        chk("hold_stb", stb_cnt - base, 1);
        chk("hold_err", frame_err, 1'b0);

        // reset mid-frame, then a full frame
        do_reset();
        base = stb_cnt;
        spi_cs_n = 1'b0;
        clks(8);
        send_bits(16'h81FF, 0, 11, rb);
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        send_bits(16'h81FF, 12, 15, rb);
        clks(4);
        spi_cs_n = 1'b1;
        clks(10);
        chk("mid_cfg0", cfg, 64'd0);
        chk("mid_stb0", stb_cnt - base, 0);
        frame(16'h8133, 10, rb);
        chk("mid_cfg", cfg, 64'h0000_0000_0000_3300);
        chk("mid_stb", stb_cnt - base, 1);
        chk("mid_err", frame_err, 1'b0);

        // read frame
        do_reset();
        base = stb_cnt;
        frame(16'h853C, 10, rb);
        miso_hi = 0;
        frame(16'h0500, 10, rb);
        chk("rd_cfg", cfg, 64'h0000_3C00_0000_0000);
        chk("rd_stb", stb_cnt - base, 1);
        chk("rd_err", frame_err, 1'b0);
`ifdef SPI_CFG_READBACK_EN
        chk("rd_miso", rb, 8'h3C);
`else
        chk("rd_miso", rb, 8'h00);
        chk("rd_miso_hi", miso_hi, 0);
`endif
        chk("rd_miso_idle", spi_miso, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
